// File: rtl/gemini_pipe_pkg.sv
// Shared definitions for the EX->LSU1 pipeline stage.
// Payload layout per lane (104 bits, MSB first):
//   pc[103:72] alu_res[71:40] in_delay_slot[39] w_reg_ena[38]
//   w_reg_dst[37:33] wb_reg_sel[32] rt_data[31:0]
package gemini_pipe_pkg;

  localparam int unsigned PAYLOAD_W     = 104;
  localparam int unsigned LANES_DEFAULT = 2;

  localparam int unsigned PC_LSB    = 72;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned ALU_LSB   = 40;
  localparam int unsigned ALU_W     = 32;
  localparam int unsigned DLY_BIT   = 39;
  localparam int unsigned WENA_BIT  = 38;
  localparam int unsigned DST_LSB   = 33;
  localparam int unsigned DST_W     = 5;
  localparam int unsigned WBSEL_BIT = 32;
  localparam int unsigned RT_LSB    = 0;
  localparam int unsigned RT_W      = 32;

  // One lane of instruction payload; bit positions match the constants above.
  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [ALU_W-1:0] alu_res;
    logic             in_delay_slot;
    logic             w_reg_ena;
    logic [DST_W-1:0] w_reg_dst;
    logic             wb_reg_sel;
    logic [RT_W-1:0]  rt_data;
  } lane_payload_t;

  // Extract the pc field from a raw lane payload.
  function automatic logic [PC_W-1:0] payload_pc(input logic [PAYLOAD_W-1:0] p);
    return p[PC_LSB +: PC_W];
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of the EX->LSU1 stage: valid bit, per-lane mask and data.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture in_mask/in_data and mark valid
//   clear      : drop contents to invalid/zero (wins over load)
//   in_mask    : LANES per-lane valid of the beat being loaded
//   in_data    : LANES*DATA_W payload being loaded
//   vld, mask, data : registered contents
module pipe_slot
  import gemini_pipe_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEFAULT,
  parameter int unsigned DATA_W = PAYLOAD_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic [LANES-1:0]        in_mask,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    vld,
  output logic [LANES-1:0]        mask,
  output logic [LANES*DATA_W-1:0] data
);

  // Entry register; cleared contents are all zero, not just invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      mask <= '0;
      data <= '0;
    end else if (clear) begin
      vld  <= 1'b0;
      mask <= '0;
      data <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      mask <= in_mask;
      data <= in_data;
    end
  end

endmodule

// File: rtl/ex_lsu1p_skid.sv
// EX->LSU1 stage register with valid/ready handshake and optional skid entry.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : discard the incoming beat this cycle (stored beats kept)
//   exception_flush     : clear all stored beats (highest priority)
//   up_valid / up_ready : upstream handshake
//   up_lane_vld/kill    : per-lane valid and squash of the incoming beat
//   up_data             : lane i payload at [i*DATA_W +: DATA_W]
//   dn_valid / dn_ready : downstream handshake towards LSU1
//   dn_lane_vld, dn_data: presented beat
//   occ                 : number of stored beats (0..2)
module ex_lsu1p_skid
  import gemini_pipe_pkg::*;
#(
  parameter int unsigned LANES   = LANES_DEFAULT,
  parameter int unsigned DATA_W  = PAYLOAD_W,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    exception_flush,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [LANES-1:0]        up_lane_vld,
  input  logic [LANES-1:0]        up_lane_kill,
  input  logic [LANES*DATA_W-1:0] up_data,
  output logic                    dn_valid,
  input  logic                    dn_ready,
  output logic [LANES-1:0]        dn_lane_vld,
  output logic [LANES*DATA_W-1:0] dn_data,
  output logic [1:0]              occ
);

  localparam int unsigned BEAT_W = LANES * DATA_W;

  logic [LANES-1:0]  eff_c;
  logic [BEAT_W-1:0] eff_data_c;
  logic              accept_c;
  logic              pop_c;
  logic              main_free_c;

  logic              main_load_c;
  logic              main_clear_c;
  logic              skid_load_c;
  logic              skid_clear_c;
  logic [LANES-1:0]  main_in_mask_c;
  logic [BEAT_W-1:0] main_in_data_c;

  logic              main_vld;
  logic [LANES-1:0]  main_mask;
  logic [BEAT_W-1:0] main_data;
  logic              skid_vld;
  logic [LANES-1:0]  skid_mask;
  logic [BEAT_W-1:0] skid_data;

  // Killed or invalid lanes are stored as zeros so they can never write back.
  always_comb begin
    eff_c      = up_lane_vld & ~up_lane_kill;
    eff_data_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      if (eff_c[i]) begin
        eff_data_c[i*DATA_W +: DATA_W] = up_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Flushed or fully-killed beats are consumed by the handshake but not stored.
  assign accept_c    = up_valid & up_ready & ~flush & ~exception_flush & (|eff_c);
  assign pop_c       = main_vld & dn_ready;
  assign main_free_c = ~main_vld | pop_c;

  // Entry steering: skid is always older than a new beat, keeping FIFO order.
  always_comb begin
    main_load_c    = 1'b0;
    main_clear_c   = 1'b0;
    skid_load_c    = 1'b0;
    skid_clear_c   = 1'b0;
    main_in_mask_c = eff_c;
    main_in_data_c = eff_data_c;

    if (exception_flush) begin
      main_clear_c = 1'b1;
      skid_clear_c = 1'b1;
    end else if (main_free_c) begin
      if (skid_vld) begin
        main_load_c    = 1'b1;
        main_in_mask_c = skid_mask;
        main_in_data_c = skid_data;
        if (accept_c) begin
          skid_load_c = 1'b1;
        end else begin
          skid_clear_c = 1'b1;
        end
      end else if (accept_c) begin
        main_load_c = 1'b1;
      end else begin
        main_clear_c = 1'b1;
      end
    end else if (accept_c) begin
      skid_load_c = 1'b1;
    end
  end

  pipe_slot #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load    (main_load_c),
    .clear   (main_clear_c),
    .in_mask (main_in_mask_c),
    .in_data (main_in_data_c),
    .vld     (main_vld),
    .mask    (main_mask),
    .data    (main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_slot #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
      ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (skid_load_c),
        .clear   (skid_clear_c),
        .in_mask (eff_c),
        .in_data (eff_data_c),
        .vld     (skid_vld),
        .mask    (skid_mask),
        .data    (skid_data)
      );

      // Ready comes straight from a flop: no input-to-output path upstream.
      assign up_ready = ~skid_vld;
    end else begin : g_noskid
      logic unused_skid_ctl;

      assign skid_vld        = 1'b0;
      assign skid_mask       = '0;
      assign skid_data       = '0;
      assign unused_skid_ctl = skid_load_c | skid_clear_c;

      // Single entry: can take a beat when empty or draining this cycle.
      assign up_ready = ~main_vld | dn_ready;
    end
  endgenerate

  assign dn_valid    = main_vld;
  assign dn_lane_vld = main_mask;
  assign dn_data     = main_data;
  assign occ         = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: tb/tb_ex_lsu1p_skid.sv
// Bench for ex_lsu1p_skid: one skid-enabled and one skid-less instance share
// stimulus; each is checked every cycle against a queue-based model, and
// directed scenarios add literal expectations.
module tb_ex_lsu1p_skid;
  import gemini_pipe_pkg::*;

  localparam int unsigned LN = 2;
  localparam int unsigned BW = LN * PAYLOAD_W;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          exception_flush;
  logic          up_valid;
  logic          dn_ready;
  logic [LN-1:0] up_lane_vld;
  logic [LN-1:0] up_lane_kill;
  logic [BW-1:0] up_data;

  logic          up_ready1, dn_valid1, up_ready0, dn_valid0;
  logic [LN-1:0] dn_lane_vld1, dn_lane_vld0;
  logic [BW-1:0] dn_data1, dn_data0;
  logic [1:0]    occ1, occ0;

  ex_lsu1p_skid #(.LANES(LN), .DATA_W(PAYLOAD_W), .SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exception_flush),
    .up_valid(up_valid), .up_ready(up_ready1), .up_lane_vld(up_lane_vld),
    .up_lane_kill(up_lane_kill), .up_data(up_data), .dn_valid(dn_valid1),
    .dn_ready(dn_ready), .dn_lane_vld(dn_lane_vld1), .dn_data(dn_data1), .occ(occ1)
  );

  ex_lsu1p_skid #(.LANES(LN), .DATA_W(PAYLOAD_W), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .exception_flush(exception_flush),
    .up_valid(up_valid), .up_ready(up_ready0), .up_lane_vld(up_lane_vld),
    .up_lane_kill(up_lane_kill), .up_data(up_data), .dn_valid(dn_valid0),
    .dn_ready(dn_ready), .dn_lane_vld(dn_lane_vld0), .dn_data(dn_data0), .occ(occ0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [LN-1:0] mask;
    logic [BW-1:0] data;
  } beat_t;

  beat_t q1[$];
  beat_t q0[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Two-lane beat: lane0 pc as given, lane1 pc+4 with selectable write enable.
  function automatic logic [BW-1:0] mk_beat(input logic [31:0] pc0, input logic wena1);
    lane_payload_t l0, l1;
    l0.pc = pc0;          l0.alu_res = $urandom; l0.in_delay_slot = 1'b0;
    l0.w_reg_ena = 1'b1;  l0.w_reg_dst = 5'($urandom); l0.wb_reg_sel = 1'($urandom);
    l0.rt_data = $urandom;
    l1.pc = pc0 + 32'd4;  l1.alu_res = $urandom; l1.in_delay_slot = 1'b1;
    l1.w_reg_ena = wena1; l1.w_reg_dst = 5'($urandom); l1.wb_reg_sel = 1'($urandom);
    l1.rt_data = $urandom;
    return {l1, l0};
  endfunction

  function automatic beat_t incoming();
    beat_t b;
    b.mask = up_lane_vld & ~up_lane_kill;
    b.data = '0;
    for (int i = 0; i < int'(LN); i++)
      if (b.mask[i]) b.data[i*PAYLOAD_W +: PAYLOAD_W] = up_data[i*PAYLOAD_W +: PAYLOAD_W];
    return b;
  endfunction

  // Stage capacity 2 with skid: accepts whenever fewer than two beats are held.
  function automatic logic ready1_m();
    return q1.size() < 2;
  endfunction

  // Capacity 1 without skid: accepts when empty or the held beat leaves now.
  function automatic logic ready0_m();
    return (q0.size() == 0) || dn_ready;
  endfunction

  task automatic compare_all();
    check("dut1.dn_valid",    dn_valid1,    q1.size() > 0);
    check("dut1.dn_lane_vld", dn_lane_vld1, q1.size() > 0 ? q1[0].mask : '0);
    check("dut1.dn_data",     dn_data1,     q1.size() > 0 ? q1[0].data : '0);
    check("dut1.occ",         occ1,         q1.size());
    check("dut1.up_ready",    up_ready1,    ready1_m());
    check("dut0.dn_valid",    dn_valid0,    q0.size() > 0);
    check("dut0.dn_lane_vld", dn_lane_vld0, q0.size() > 0 ? q0[0].mask : '0);
    check("dut0.dn_data",     dn_data0,     q0.size() > 0 ? q0[0].data : '0);
    check("dut0.occ",         occ0,         q0.size());
    check("dut0.up_ready",    up_ready0,    ready0_m());
  endtask

  // Advance both models by the clock edge that follows the current inputs.
  task automatic model_update();
    beat_t b;
    logic  r1, r0, take;
    r1   = ready1_m();
    r0   = ready0_m();
    b    = incoming();
    take = up_valid && !flush && (b.mask != '0);
    if (rst || exception_flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && dn_ready) void'(q1.pop_front());
      if (q0.size() > 0 && dn_ready) void'(q0.pop_front());
      if (take && r1) q1.push_back(b);
      if (take && r0) q0.push_back(b);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs compared on the falling edge.
  task automatic step();
    @(negedge clk);
    compare_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc0, input logic [1:0] vld, input logic [1:0] kill,
                       input logic wena1);
    up_valid     = 1'b1;
    up_lane_vld  = vld;
    up_lane_kill = kill;
    up_data      = mk_beat(pc0, wena1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; exception_flush = 1'b0; up_valid = 1'b0;
    dn_ready = 1'b0; up_lane_vld = '0; up_lane_kill = '0; up_data = '0;
    #2 rst = 1'b1;
    #1;
    check("reset dn_valid", dn_valid1, 1'b0);
    check("reset occ",      occ1,      2'd0);
    check("reset up_ready", up_ready1, 1'b1);
    check("reset dn_data",  dn_data1,  '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single beat into an empty stage appears on the next cycle.
    dn_ready = 1'b1;
    offer(32'hBFC0_0000, 2'b11, 2'b00, 1'b1);
    step();
    up_valid = 1'b0;
    check("single dn_valid",  dn_valid1,    1'b1);
    check("single lane_vld",  dn_lane_vld1, 2'b11);
    check("single pc0",       dn_data1[PC_LSB +: 32], 32'hBFC0_0000);
    check("single pc1",       dn_data1[PAYLOAD_W + PC_LSB +: 32], 32'hBFC0_0004);
    check("single occ",       occ1,         2'd1);
    // Skid-less ready follows dn_ready combinationally while a beat is held.
    dn_ready = 1'b0;
    #1 check("noskid ready low",  up_ready0, 1'b0);
    dn_ready = 1'b1;
    #1 check("noskid ready high", up_ready0, 1'b1);
    step();

    // Backpressure: A and B stored, C held by the source until accepted.
    dn_ready = 1'b0;
    offer(32'h0000_0100, 2'b11, 2'b00, 1'b1);
    step();
    check("bp occ after A", occ1, 2'd1);
    offer(32'h0000_0200, 2'b11, 2'b00, 1'b1);
    step();
    check("bp occ after B",   occ1,      2'd2);
    check("bp ready after B", up_ready1, 1'b0);
    offer(32'h0000_0300, 2'b11, 2'b00, 1'b1);
    step();
    check("bp head A", dn_data1[PC_LSB +: 32], 32'h0000_0100);
    dn_ready = 1'b1;
    step();
    check("bp head B", dn_data1[PC_LSB +: 32], 32'h0000_0200);
    step();
    check("bp head C", dn_data1[PC_LSB +: 32], 32'h0000_0300);
    check("bp occ C",  occ1, 2'd1);
    up_valid = 1'b0;
    step();
    check("bp drained", occ1, 2'd0);

    // Kill lane 1: stored as zeros with its mask bit clear.
    offer(32'h0000_0400, 2'b11, 2'b10, 1'b1);
    step();
    check("kill lane_vld", dn_lane_vld1, 2'b01);
    check("kill lane1 zero", dn_data1[PAYLOAD_W +: PAYLOAD_W], '0);
    dn_ready = 1'b0;
    offer(32'h0000_0500, 2'b11, 2'b11, 1'b1);
    step();
    check("kill all occ", occ1, 2'd1);

    // Branch flush with a held beat: new beat dropped, held beat kept.
    flush = 1'b1;
    offer(32'h0000_0600, 2'b11, 2'b00, 1'b1);
    step();
    flush = 1'b0;
    check("flush occ",  occ1, 2'd1);
    check("flush head", dn_data1[PC_LSB +: 32], 32'h0000_0400);

    // Exception flush at full occupancy with pop and offer in the same cycle.
    offer(32'h0000_0700, 2'b11, 2'b00, 1'b1);
    step();
    check("exc pre occ", occ1, 2'd2);
    exception_flush = 1'b1;
    dn_ready = 1'b1;
    offer(32'h0000_0800, 2'b11, 2'b00, 1'b1);
    step();
    exception_flush = 1'b0;
    up_valid = 1'b0;
    check("exc dn_valid", dn_valid1, 1'b0);
    check("exc occ",      occ1,      2'd0);
    check("exc up_ready", up_ready1, 1'b1);
    check("exc dn_data",  dn_data1,  '0);

    // Asynchronous reset between edges at full occupancy.
    dn_ready = 1'b0;
    offer(32'h0000_0900, 2'b11, 2'b00, 1'b1);
    step();
    offer(32'h0000_0A00, 2'b01, 2'b00, 1'b0);
    step();
    up_valid = 1'b0;
    check("areset pre occ", occ1, 2'd2);
    #2 rst = 1'b1;
    #1;
    check("areset dn_valid",  dn_valid1, 1'b0);
    check("areset occ",       occ1,      2'd0);
    check("areset dn_data",   dn_data1,  '0);
    check("areset up_ready",  up_ready1, 1'b1);
    check("areset dut0 valid", dn_valid0, 1'b0);
    q1.delete();
    q0.delete();
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic against the models.
    for (int n = 0; n < 3000; n++) begin
      up_valid        = ($urandom_range(0, 3) != 0);
      up_lane_vld     = 2'($urandom);
      up_lane_kill    = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      up_data         = mk_beat($urandom, 1'($urandom));
      flush           = ($urandom_range(0, 15) == 0);
      exception_flush = ($urandom_range(0, 31) == 0);
      dn_ready        = ($urandom_range(0, 9) < 6);
      step();
    end
    flush = 1'b0; exception_flush = 1'b0; up_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_lsu1p_skid.md
Name: ex_lsu1p_skid

Overview:
- Parametrised EX→LSU1 stage register for the dual-issue pipeline.
- Each lane carries one instruction payload: pc, alu_res, in_delay_slot, w_reg_ena, w_reg_dst, wb_reg_sel, rt_data.
- Replaces the hold-on-stall register with a valid/ready handshake and a one-entry skid buffer, so the upstream ready is a registered signal.
- Adds a per-lane kill mask for delay-slot and second-lane squash, plus an occupancy output for hazard logic.

Parameters:
LANES, 2, issue width; number of instruction lanes per beat
DATA_W, 104, payload bits per lane: 32 pc + 32 alu_res + 1 dly + 1 wena + 5 dst + 1 wbsel + 32 rt
SKID_EN, 1, 1 = two-entry (main+skid) storage; 0 = main only, up_ready combinational from dn_ready

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  branch flush; discards the incoming beat this cycle, stored beats kept
exception_flush  in  1  clears all stored beats; highest priority
up_valid  in  1  upstream beat present
up_ready  out  1  stage can accept a beat
up_lane_vld  in  LANES  per-lane valid of incoming beat
up_lane_kill  in  LANES  per-lane squash of incoming beat
up_data  in  LANES*DATA_W  lane i payload at [i*DATA_W +: DATA_W]
dn_valid  out  1  beat presented to LSU1
dn_ready  in  1  LSU1 consumes beat
dn_lane_vld  out  LANES  per-lane valid of presented beat
dn_data  out  LANES*DATA_W  presented payload
occ  out  2  stored beats, 0..2

Behaviour:
- Reset (async, rst=1): main and skid invalid, lane masks 0, data 0, occ=0, dn_valid=0, up_ready=1. Outputs are stable within rst assertion without a clock edge.
- Effective incoming lane mask: eff = up_lane_vld & ~up_lane_kill.
- A beat is accepted when up_valid & up_ready & !flush & !exception_flush & (eff != 0).
- A beat with flush=1 or eff==0 is consumed, not stored; up_ready is still honoured.
- Stored payload per lane: up_data where eff[i]=1, else all zeros, so a killed lane has w_reg_ena=0.
- dn_valid = main valid; dn_lane_vld = main mask; dn_data = main data. All are registered outputs with no combinational input→output path when SKID_EN=1.
- Pop: dn_valid & dn_ready.
- Main update, per cycle in priority order:
  - exception_flush: main and skid cleared to invalid/zero; occ=0 next cycle; accept and pop ignored.
  - Main empty, or pop: main ← skid if skid valid, else ← accepted beat, else invalid/zero.
  - Main full, no pop, accepted beat: beat → skid (SKID_EN=1 only).
- Skid: cleared when it moves to main. Simultaneous skid→main and accept: accepted beat goes to skid.
- up_ready:
  - SKID_EN=1: registered, equals !skid_valid.
  - SKID_EN=0: !main_valid | dn_ready.
- Latency: accepted beat appears on dn_* the next cycle if main was empty or popped; throughput 1 beat/cycle.
- Ordering is strictly FIFO: skid is always older than any new beat.
- occ = main_valid + skid_valid.
- Full (occ=2): up_ready=0; an upstream beat with up_valid=1 is held by the source, never dropped.
- flush during stall: stored beats unchanged.
- exception_flush with rst already deasserted: clears state synchronously at the edge.
- Reset mid-transfer: the beat is lost, and the upstream replays it after the exception/reset redirect.

Decomposition:
- Package gemini_pipe_pkg holds:
  - Payload field LSB/width constants: PC_LSB=72, ALU_LSB=40, DLY_BIT=39, WENA_BIT=38, DST_LSB=33 (5 bits), WBSEL_BIT=32, RT_LSB=0.
  - PAYLOAD_W=104.
  - Default LANES=2.
- Sub-module pipe_slot: one storage entry holding valid, LANES mask and LANES*DATA_W data, with load/clear inputs and async reset. Instantiated as main and, under a generate on SKID_EN, as skid.

Test Plan:
- Reset release, single beat: up_valid=1, up_lane_vld=2'b11, lane0 pc=0xBFC00000, lane1 pc=0xBFC00004, dn_ready=1 → next cycle dn_valid=1, dn_lane_vld=2'b11, pc fields match; occ=1.
- Backpressure: dn_ready=0 for 3 cycles while 3 beats offered → beats A and B stored, occ=2, up_ready=0 from the cycle after B. Raise dn_ready → A, B, C emerge in order, no loss or duplication.
- Kill: up_lane_vld=2'b11, up_lane_kill=2'b10, lane1 wena=1 → dn_lane_vld=2'b01, lane1 payload all zeros (wena=0). Kill=2'b11 → nothing stored, occ unchanged.
- flush with occ=1 and dn_ready=0, new beat offered → beat dropped, stored beat held, occ=1.
- exception_flush at occ=2 with simultaneous pop and accept → next cycle dn_valid=0, occ=0, up_ready=1, dn_data=0.
- Async reset asserted between clock edges at occ=2 → dn_valid, occ and dn_data go to 0 before the next edge. Repeat with SKID_EN=0: up_ready tracks dn_ready combinationally.
